// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART 8N1 transmitter fed by a small ready/valid byte FIFO
// Defining UART_TX_PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [7:0]                       data_i,
    input  logic                             valid_i,
    output logic                             ready_o,
    output logic                             tx_o,
    output logic                             busy_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] count_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    logic parity_bit;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic          baud_last;
    logic          fifo_empty;
    logic          push;
    logic          pop;

    assign ready_o    = (count_o != COUNT_FULL);
    assign fifo_empty = (count_o == '0);
    assign baud_last  = (baud_cnt == BAUD_LAST);
    assign push       = valid_i & ready_o;
    // Popping on the last STOP cycle chains frames with no idle gap.
    assign pop        = !fifo_empty && ((state == IDLE) || ((state == STOP) && baud_last));
    // The pop edge moves state out of IDLE while count drops, so busy never dips between frames.
    assign busy_o     = (state != IDLE) || !fifo_empty;

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state     <= IDLE;
            tx_o      <= 1'b1;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_o   <= '0;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count_o <= count_o + 1'b1;
            end else if (pop && !push) begin
                count_o <= count_o - 1'b1;
            end

            if (pop) begin
                state     <= START;
                tx_o      <= 1'b0;
                baud_cnt  <= '0;
                bit_idx   <= '0;
                shift_reg <= fifo_mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                parity_bit <= ^fifo_mem[rd_ptr];
`endif
            end else begin
                case (state)
                    IDLE: begin
                        tx_o     <= 1'b1;
                        baud_cnt <= '0;
                    end
                    START: begin
                        if (baud_last) begin
                            state    <= DATA;
                            tx_o     <= shift_reg[0];
                            baud_cnt <= '0;
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (baud_last) begin
                            baud_cnt <= '0;
                            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                                state <= PARITY;
                                tx_o  <= parity_bit;
`else
                                state <= STOP;
                                tx_o  <= 1'b1;
`endif
                            end else begin
                                bit_idx   <= bit_idx + 3'd1;
                                tx_o      <= shift_reg[1];
                                shift_reg <= {1'b0, shift_reg[7:1]};
                            end
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    PARITY: begin
                        if (baud_last) begin
                            state    <= STOP;
                            tx_o     <= 1'b1;
                            baud_cnt <= '0;
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                    end
`endif
                    STOP: begin
                        if (baud_last) begin
                            state    <= IDLE;
                            tx_o     <= 1'b1;
                            baud_cnt <= '0;
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        tx_o  <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo at CLKS_PER_BIT=4, FIFO_DEPTH=4
module tb_uart_tx_fifo;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid;
    logic [7:0] data;
    logic       ready;
    logic       tx;
    logic       busy;
    logic [2:0] count;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .data_i  (data),
        .valid_i (valid),
        .ready_o (ready),
        .tx_o    (tx),
        .busy_o  (busy),
        .count_o (count)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    bit saw_full = 1'b0;

    // Reference: a byte queue plus a queue of per-cycle line levels for frames already started.
    logic [7:0] m_fifo[$];
    logic       m_line[$];
    logic       m_tx     = 1'b1;
    logic       m_active = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
        logic       par;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name, input int limit);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: no progress within %0d cycles, expected completion", name, limit);
    endtask

    task automatic model_step(input logic rst_s, input logic valid_s, input logic [7:0] data_s);
        bit         ready_pre;
        logic [7:0] b;
        logic       lvl;
        if (!rst_s) begin
            m_fifo.delete();
            m_line.delete();
            m_tx     = 1'b1;
            m_active = 1'b0;
            return;
        end
        ready_pre = (m_fifo.size() != DEPTH);
        if (m_line.size() == 0 && m_fifo.size() != 0) begin
            b = m_fifo.pop_front();
            for (int i = 0; i < NBITS; i++) begin
                if (i == 0)               lvl = 1'b0;
                else if (i <= 8)          lvl = b[i-1];
                else if (i == NBITS - 1)  lvl = 1'b1;
                else                      lvl = ^b;
                for (int c = 0; c < CPB; c++) m_line.push_back(lvl);
            end
        end
        if (m_line.size() != 0) begin
            m_tx     = m_line.pop_front();
            m_active = 1'b1;
        end else begin
            m_tx     = 1'b1;
            m_active = 1'b0;
        end
        if (valid_s && ready_pre) m_fifo.push_back(data_s);
    endtask

    initial forever begin
        @(posedge clk);
        model_step(rst_n, valid, data);
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("tx", {31'd0, tx}, {31'd0, m_tx});
            check("busy", {31'd0, busy}, {31'd0, (m_active || m_fifo.size() != 0)});
            check("count", {29'd0, count}, m_fifo.size());
            check("ready", {31'd0, ready}, {31'd0, (m_fifo.size() != DEPTH)});
            if (count == 3'd4 && !ready) saw_full = 1'b1;
        end
    end

    function automatic logic exp_bit(input vec_t v, input int i);
        if (i < 9)          return v.frame[i];
        if (i == NBITS - 1) return v.frame[9];
        return v.par;
    endfunction

    // Called just after a negedge; returns just after the negedge following the accepting edge.
    task automatic push_byte(input logic [7:0] b);
        int guard = 0;
        data  = b;
        valid = 1'b1;
        while (!ready && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) bound_fail("push_ready", 500);
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (busy) bound_fail("idle", limit);
    endtask

    initial begin
        vec_t vecs[6];
        int   cnt;
        int   guard;

        vecs[0] = '{8'h55, 10'b1_01010101_0, 1'b0};
        vecs[1] = '{8'h12, 10'b1_00010010_0, 1'b0};
        vecs[2] = '{8'hA5, 10'b1_10100101_0, 1'b0};
        vecs[3] = '{8'h07, 10'b1_00000111_0, 1'b1};
        vecs[4] = '{8'h03, 10'b1_00000011_0, 1'b0};
        vecs[5] = '{8'hFF, 10'b1_11111111_0, 1'b0};

        rst_n = 1'b0;
        valid = 1'b0;
        data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_count", {29'd0, count}, 32'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Single frames from idle, sampled mid-bit against hand-written line patterns.
        for (int v = 0; v < 6; v++) begin
            push_byte(vecs[v].data);
            @(negedge clk);
            for (int i = 0; i < NBITS; i++) begin
                @(negedge clk);
                check($sformatf("vec%0d_bit%0d", v, i), {31'd0, tx}, {31'd0, exp_bit(vecs[v], i)});
                repeat (CPB - 1) @(negedge clk);
            end
            check($sformatf("vec%0d_idle", v), {31'd0, busy}, 32'd0);
            check($sformatf("vec%0d_count", v), {29'd0, count}, 32'd0);
        end

        // Back-to-back frames: busy spans both with no gap.
        push_byte(8'h12);
        push_byte(8'hA5);
        cnt = 0;
        while (busy && cnt < 1000) begin
            cnt++;
            @(negedge clk);
        end
        check("b2b_cycles", cnt, 2 * NBITS * CPB);

        // Stream six bytes with valid held; the FIFO fills and back-pressures.
        for (int i = 0; i < 6; i++) push_byte(8'hC0 + 8'(i));
        check("saw_full", {31'd0, saw_full}, 32'd1);
        wait_idle(2000);

        // Push on the same edge as the STOP-end pop.
        push_byte(8'h31);
        push_byte(8'h32);
        push_byte(8'h33);
        push_byte(8'h34);
        guard = 0;
        while (!(m_line.size() == 0 && m_active) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) bound_fail("stop_end", 200);
        check("pre_pushpop_count", {29'd0, count}, 32'd3);
        data  = 8'h35;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        check("pushpop_count", {29'd0, count}, 32'd3);
        wait_idle(2000);

        // Reset during data bit 3 of 0xFF with two bytes queued.
        push_byte(8'hFF);
        push_byte(8'h11);
        push_byte(8'h22);
        repeat (16) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_tx", {31'd0, tx}, 32'd1);
        check("midrst_count", {29'd0, count}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        repeat (60) @(negedge clk);
        check("midrst_quiet", {31'd0, busy}, 32'd0);

        // Randomized traffic with occasional resets, dense then sparse.
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 399) != 0);
            valid = (c < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
            data  = 8'($urandom);
            @(negedge clk);
        end
        rst_n = 1'b1;
        valid = 1'b0;
        wait_idle(5000);
        check("final_count", {29'd0, count}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
